// File: rtl/skinny_round_ctrl.sv
// skinny_round_ctrl: control FSM upstream of mode_top for one SKINNY-128-384 block.
// Sequence: CLR (clear datapath) -> LOAD (BEATS serial beats) -> RUN (4 rounds per cycle)
// -> UNLOAD (BEATS serial beats) -> IDLE.
// Optional feature: define CTRL_ABORT_EN to add the abort input and aborted output.
module skinny_round_ctrl #(
    parameter int unsigned ROUNDS = 56,
    parameter int unsigned BEATS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef CTRL_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       busy,
    output logic       load_req,
    output logic       pdo_valid,
    output logic       done,
    output logic       srst,
    output logic       xrst,
    output logic       yrst,
    output logic       zrst,
    output logic       senc,
    output logic       xenc,
    output logic       yenc,
    output logic       zenc,
    output logic       sse,
    output logic       xse,
    output logic       yse,
    output logic       zse,
    output logic [5:0] constant,
    output logic [5:0] constant2,
    output logic [5:0] constant3,
    output logic [5:0] constant4,
    output logic [5:0] round_cnt
);

    localparam logic [2:0] LastBeat = 3'(BEATS - 1);
    localparam logic [5:0] LastRun  = 6'(ROUNDS / 4 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLoad,
        StRun,
        StUnload
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [5:0] rc_q, rc_d;
    logic [5:0] round_cnt_q, round_cnt_d;
    logic [5:0] rc1, rc2, rc3, rc4;
    logic       kill;  // abort accepted this cycle (never in IDLE)

    // One step of the 6-bit round-constant LFSR.
    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    assign rc1 = rc_step(rc_q);
    assign rc2 = rc_step(rc1);
    assign rc3 = rc_step(rc2);
    assign rc4 = rc_step(rc3);

`ifdef CTRL_ABORT_EN
    logic aborted_q;

    assign kill    = abort && (state_q != StIdle);
    assign aborted = aborted_q;

    // Flag the cycle immediately following an accepted abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= kill;
        end
    end
`else
    assign kill = 1'b0;
`endif

    // State, shared beat counter, LFSR and RUN-cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= 3'd0;
            rc_q        <= 6'd0;
            round_cnt_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rc_q        <= rc_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    // Next-state logic for the sequence and its counters.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rc_d        = rc_q;
        round_cnt_d = round_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClr;
                end
            end
            StClr: begin
                beat_d      = 3'd0;
                rc_d        = 6'd0;
                round_cnt_d = 6'd0;
                state_d     = StLoad;
            end
            StLoad: begin
                if (beat_q == LastBeat) begin
                    beat_d  = 3'd0;
                    state_d = StRun;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            StRun: begin
                rc_d        = rc4;
                round_cnt_d = round_cnt_q + 6'd1;
                if (round_cnt_q == LastRun) begin
                    beat_d  = 3'd0;
                    state_d = StUnload;
                end
            end
            StUnload: begin
                if (beat_q == LastBeat) begin
                    beat_d  = 3'd0;
                    state_d = StIdle;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d     = StIdle;
            beat_d      = 3'd0;
            rc_d        = 6'd0;
            round_cnt_d = 6'd0;
        end
    end

    // Moore strobes per state; done is gated so an abort on the last beat suppresses it.
    always_comb begin
        busy      = (state_q != StIdle);
        load_req  = 1'b0;
        pdo_valid = 1'b0;
        done      = 1'b0;
        srst      = 1'b0;
        xrst      = 1'b0;
        yrst      = 1'b0;
        zrst      = 1'b0;
        senc      = 1'b0;
        xenc      = 1'b0;
        yenc      = 1'b0;
        zenc      = 1'b0;
        sse       = 1'b0;
        xse       = 1'b0;
        yse       = 1'b0;
        zse       = 1'b0;
        constant  = 6'd0;
        constant2 = 6'd0;
        constant3 = 6'd0;
        constant4 = 6'd0;
        round_cnt = round_cnt_q;
        unique case (state_q)
            StIdle: ;
            StClr: begin
                srst = 1'b1;
                xrst = 1'b1;
                yrst = 1'b1;
                zrst = 1'b1;
            end
            StLoad: begin
                senc     = 1'b1;
                sse      = 1'b1;
                xenc     = 1'b1;
                xse      = 1'b1;
                yenc     = 1'b1;
                yse      = 1'b1;
                load_req = 1'b1;
            end
            StRun: begin
                senc      = 1'b1;
                xenc      = 1'b1;
                yenc      = 1'b1;
                zenc      = 1'b1;
                constant  = rc1;
                constant2 = rc2;
                constant3 = rc3;
                constant4 = rc4;
            end
            StUnload: begin
                senc      = 1'b1;
                sse       = 1'b1;
                pdo_valid = 1'b1;
                done      = (beat_q == LastBeat) && !kill;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// tb_skinny_round_ctrl: randomized bench for skinny_round_ctrl against a cycle-position model.
// Define CTRL_ABORT_EN to also exercise abort/aborted.
`timescale 1ns/1ps
module tb_skinny_round_ctrl;

    localparam int unsigned ROUNDS = 56;
    localparam int unsigned BEATS  = 4;
    localparam int RunCycles = ROUNDS / 4;
    localparam int TClr      = 1;
    localparam int TLoad0    = 2;
    localparam int TRun0     = TLoad0 + BEATS;
    localparam int TUnl0     = TRun0 + RunCycles;
    localparam int TLast     = TUnl0 + BEATS - 1;
`ifdef CTRL_ABORT_EN
    localparam bit HasAbort = 1'b1;
`else
    localparam bit HasAbort = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort_in;
    logic       aborted;
    logic       busy, load_req, pdo_valid, done;
    logic       srst, xrst, yrst, zrst;
    logic       senc, xenc, yenc, zenc;
    logic       sse, xse, yse, zse;
    logic [5:0] constant, constant2, constant3, constant4;
    logic [5:0] round_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done   = 0;

    // Model: position within the block (0 = idle, 1 = CLR, ..., TLast = final UNLOAD beat).
    int         m_c      = 0;
    int         m_rcnt   = 0;
    bit         m_abd    = 1'b0;
    bit         m_valid  = 1'b0;
    logic [5:0] kseq[ROUNDS];

    skinny_round_ctrl #(
        .ROUNDS(ROUNDS),
        .BEATS (BEATS)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef CTRL_ABORT_EN
        .abort    (abort_in),
        .aborted  (aborted),
`endif
        .busy     (busy),
        .load_req (load_req),
        .pdo_valid(pdo_valid),
        .done     (done),
        .srst     (srst),
        .xrst     (xrst),
        .yrst     (yrst),
        .zrst     (zrst),
        .senc     (senc),
        .xenc     (xenc),
        .yenc     (yenc),
        .zenc     (zenc),
        .sse      (sse),
        .xse      (xse),
        .yse      (yse),
        .zse      (zse),
        .constant (constant),
        .constant2(constant2),
        .constant3(constant3),
        .constant4(constant4),
        .round_cnt(round_cnt)
    );

`ifndef CTRL_ABORT_EN
    assign aborted = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic s, input logic r, input logic a);
        logic [15:0] exp_strb;
        logic [15:0] got_strb;
        logic [23:0] exp_k;
        logic [23:0] got_k;
        bit          ab;
        int          k;
        @(negedge clk);
        start    = s;
        rst      = r;
        abort_in = a;
        #1;
        ab = HasAbort && a && (m_c != 0);
        if (done) n_done++;
        if (m_valid) begin
            exp_strb = 16'h0;
            exp_k    = 24'h0;
            if (m_c != 0) exp_strb[3] = 1'b1;
            if (m_c == TClr) begin
                exp_strb[15:12] = 4'hF;
            end else if (m_c >= TLoad0 && m_c < TRun0) begin
                exp_strb[11:9] = 3'b111;
                exp_strb[7:5]  = 3'b111;
                exp_strb[2]    = 1'b1;
            end else if (m_c >= TRun0 && m_c < TUnl0) begin
                exp_strb[11:8] = 4'hF;
                k = m_c - TRun0;
                exp_k = {kseq[4*k], kseq[4*k+1], kseq[4*k+2], kseq[4*k+3]};
            end else if (m_c >= TUnl0) begin
                exp_strb[11] = 1'b1;
                exp_strb[7]  = 1'b1;
                exp_strb[1]  = 1'b1;
                if (m_c == TLast && !ab) exp_strb[0] = 1'b1;
            end
            got_strb = {srst, xrst, yrst, zrst, senc, xenc, yenc, zenc,
                        sse, xse, yse, zse, busy, load_req, pdo_valid, done};
            got_k    = {constant, constant2, constant3, constant4};
            check_val("strobes", 32'(got_strb), 32'(exp_strb));
            check_val("consts", 32'(got_k), 32'(exp_k));
            check_val("round_cnt", 32'(round_cnt), 32'(m_rcnt));
            check_val("rst_vs_enc", 32'(|got_strb[15:12] & |got_strb[11:8]), 32'd0);
            if (HasAbort) check_val("aborted", 32'(aborted), 32'(m_abd));
            if (m_c == TRun0)
                check_val("run1_consts", 32'(got_k), 32'({6'h01, 6'h03, 6'h07, 6'h0F}));
            if (m_c == TRun0 + 1)
                check_val("run2_consts", 32'(got_k), 32'({6'h1F, 6'h3E, 6'h3D, 6'h3B}));
            if (m_c == TUnl0 - 1)
                check_val("run14_consts", 32'(got_k), 32'({6'h19, 6'h32, 6'h25, 6'h0A}));
        end
        if (r) begin
            m_c     = 0;
            m_rcnt  = 0;
            m_abd   = 1'b0;
            m_valid = 1'b1;
        end else if (m_c == 0) begin
            m_abd = 1'b0;
            if (s) m_c = 1;
        end else if (ab) begin
            m_c    = 0;
            m_rcnt = 0;
            m_abd  = 1'b1;
        end else begin
            m_abd = 1'b0;
            if (m_c == TClr) m_rcnt = 0;
            else if (m_c >= TRun0 && m_c < TUnl0) m_rcnt++;
            m_c = (m_c == TLast) ? 0 : m_c + 1;
        end
    endtask

    initial begin
        logic [5:0] r6;
        start    = 1'b0;
        rst      = 1'b1;
        abort_in = 1'b0;
        // SKINNY round-constant sequence straight from the LFSR rule.
        r6 = 6'd0;
        for (int i = 0; i < int'(ROUNDS); i++) begin
            r6      = {r6[4:0], r6[5] ^ r6[4] ^ 1'b1};
            kseq[i] = r6;
        end

        // Reset, then a single isolated block.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Start held high: exactly three blocks in 72 cycles.
        n_done = 0;
        repeat (72) step(1'b1, 1'b0, 1'b0);
        check_val("held_start_dones", 32'(n_done), 32'd3);
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Reset mid-RUN, then a fresh block.
        step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Abort at t+8 during LOAD/RUN, then a normal block.
        if (HasAbort) begin
            step(1'b1, 1'b0, 1'b0);
            repeat (7) step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            repeat (3) step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b1);
            repeat (30) step(1'b0, 1'b0, 1'b0);
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 199) == 0),
                 1'(HasAbort && ($urandom_range(0, 59) == 0)));
        end
        repeat (30) step(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
